// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light sequencer.
// Holds the mode enumeration, lamp patterns and the default step divider.
package tail_light_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLeft,
      StRight,
      StHazard,
      StError
   } state_e;

   localparam int unsigned TickDivDefault = 12500000;

   // Indexed by phase; element 0 is the rightmost entry.
   localparam logic [3:0][2:0] LeftPattern  = {3'b111, 3'b011, 3'b001, 3'b000};
   localparam logic [3:0][2:0] RightPattern = {3'b111, 3'b110, 3'b100, 3'b000};

   localparam logic [2:0] BankOff = 3'b000;
   localparam logic [2:0] BankOn  = 3'b111;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running step divider with synchronous clear.
// step is high during the cycle in which the count sits at TICK_DIV-1.
module blink_prescaler
   import tail_light_pkg::*;
#(
   parameter int unsigned TICK_DIV = TickDivDefault
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   output logic step
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] count;

   assign step = (count == CntMax);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear || step) begin
         count <= '0;
      end else begin
         count <= count + CntW'(1);
      end
   end

endmodule

// File: rtl/tail_light_ctrl.sv
// Turn/hazard/brake tail-light controller with sequenced lamp banks.
// Outputs are registered from the next state/phase, giving one cycle of input-to-output latency.
module tail_light_ctrl
   import tail_light_pkg::*;
#(
   parameter int unsigned TICK_DIV = TickDivDefault
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       left,
   input  logic       right,
   input  logic       hazard,
   input  logic       brake,
   output logic [2:0] l_signal,
   output logic [2:0] r_signal,
   output logic       error,
   output logic       step
);

   state_e     state, state_nxt;
   logic [1:0] phase, phase_nxt;
   logic       tick, change, advance;
   logic [2:0] l_nxt, r_nxt, brake_bank;
   logic       error_nxt;

   blink_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (change),
      .step    (tick)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         StIdle: begin
            if (hazard)              state_nxt = StHazard;
            else if (left && right)  state_nxt = StError;
            else if (left)           state_nxt = StLeft;
            else if (right)          state_nxt = StRight;
         end
         StLeft: begin
            if (hazard)              state_nxt = StHazard;
            else if (right)          state_nxt = StError;
            else if (!left)          state_nxt = StIdle;
         end
         StRight: begin
            if (hazard)              state_nxt = StHazard;
            else if (left)           state_nxt = StError;
            else if (!right)         state_nxt = StIdle;
         end
         StHazard: begin
            if (!hazard)             state_nxt = StIdle;
         end
         StError: begin
            if (hazard)              state_nxt = StHazard;
            else if (!left && !right) state_nxt = StIdle;
         end
         default:                    state_nxt = StIdle;
      endcase
   end

   // A mode change restarts the sequence and suppresses any coincident advance.
   assign change  = (state_nxt != state);
   assign advance = tick && !change;

   always_comb begin
      phase_nxt = phase;
      if (change) begin
         phase_nxt = 2'd0;
      end else if (advance) begin
         case (state)
            StLeft, StRight: phase_nxt = phase + 2'd1;
            StHazard:        phase_nxt = phase ^ 2'b01;
            default:         phase_nxt = 2'd0;
         endcase
      end
   end

   assign brake_bank = brake ? BankOn : BankOff;

   always_comb begin
      l_nxt     = BankOff;
      r_nxt     = BankOff;
      error_nxt = 1'b0;
      case (state_nxt)
         StIdle: begin
            l_nxt = brake_bank;
            r_nxt = brake_bank;
         end
         StLeft: begin
            l_nxt = LeftPattern[phase_nxt];
            r_nxt = brake_bank;
         end
         StRight: begin
            l_nxt = brake_bank;
            r_nxt = RightPattern[phase_nxt];
         end
         StHazard: begin
            l_nxt = {3{phase_nxt[0]}};
            r_nxt = {3{phase_nxt[0]}};
         end
         StError: begin
            error_nxt = 1'b1;
         end
         default: begin
            l_nxt = BankOff;
            r_nxt = BankOff;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= StIdle;
         phase    <= 2'd0;
         l_signal <= BankOff;
         r_signal <= BankOff;
         error    <= 1'b0;
         step     <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         l_signal <= l_nxt;
         r_signal <= r_nxt;
         error    <= error_nxt;
         step     <= advance;
      end
   end

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Bench for tail_light_ctrl: per-cycle behavioural model plus directed literal checks.
// Model tracks mode and cycles-since-entry; lamps derive arithmetically from that count.
module tb_tail_light_ctrl;

   localparam int TD = 4;
   localparam int MIdle = 0, MLeft = 1, MRight = 2, MHazard = 3, MError = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
   logic [2:0] l_signal, r_signal;
   logic       error, step;

   int checks = 0;
   int failures = 0;

   tail_light_ctrl #(
      .TICK_DIV (TD)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .left     (left),
      .right    (right),
      .hazard   (hazard),
      .brake    (brake),
      .l_signal (l_signal),
      .r_signal (r_signal),
      .error    (error),
      .step     (step)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   function automatic int next_mode(input int m, input logic l, input logic r, input logic h);
      int n;
      n = m;
      if (m == MHazard) begin
         if (!h) n = MIdle;
      end else if (h) begin
         n = MHazard;
      end else if (m == MIdle) begin
         if (l && r)  n = MError;
         else if (l)  n = MLeft;
         else if (r)  n = MRight;
      end else if (m == MLeft) begin
         if (r)       n = MError;
         else if (!l) n = MIdle;
      end else if (m == MRight) begin
         if (l)       n = MError;
         else if (!r) n = MIdle;
      end else begin
         if (!l && !r) n = MIdle;
      end
      return n;
   endfunction

   // Model: mode plus number of edges since entering it.
   int         m_mode = MIdle;
   int         m_n = 0;
   logic [2:0] exp_l, exp_r, brk;
   logic       exp_err, exp_step;

   always @(posedge clock) begin
      int nm, k, j;
      if (!reset_n) begin
         m_mode = MIdle;
         m_n = 0;
      end else begin
         nm = next_mode(m_mode, left, right, hazard);
         if (nm != m_mode) begin
            m_mode = nm;
            m_n = 0;
         end else begin
            m_n++;
         end
      end
      k = m_n / TD;
      j = k % 4;
      brk = brake ? 3'b111 : 3'b000;
      exp_step = reset_n && (m_n > 0) && (m_n % TD == 0);
      exp_err = 1'b0;
      exp_l = 3'b000;
      exp_r = 3'b000;
      if (reset_n) begin
         case (m_mode)
            MIdle:   begin exp_l = brk; exp_r = brk; end
            MLeft:   begin exp_l = 3'((1 << j) - 1); exp_r = brk; end
            MRight:  begin exp_l = brk; exp_r = 3'((7 << (3 - j)) & 7); end
            MHazard: begin exp_l = (k % 2 == 1) ? 3'b111 : 3'b000; exp_r = exp_l; end
            default: exp_err = 1'b1;
         endcase
      end
      #1;
      chk("cyc_l_signal", l_signal, exp_l);
      chk("cyc_r_signal", r_signal, exp_r);
      chk("cyc_error", {2'b00, error}, {2'b00, exp_err});
      chk("cyc_step", {2'b00, step}, {2'b00, exp_step});
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic l, r, h, b;
      int   cycles;
   } vec_t;

   vec_t tbl[10] = '{
      '{1'b0, 1'b0, 1'b1, 1'b1, 9}, '{1'b0, 1'b0, 1'b0, 1'b0, 2},
      '{1'b0, 1'b1, 1'b0, 1'b0, 6}, '{1'b1, 1'b1, 1'b0, 1'b0, 3},
      '{1'b1, 1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b1, 1'b0, 5},
      '{1'b0, 1'b0, 1'b0, 1'b1, 3}, '{1'b0, 1'b1, 1'b0, 1'b0, 5},
      '{1'b0, 1'b1, 1'b1, 1'b1, 2}, '{1'b0, 1'b0, 1'b0, 1'b0, 3}
   };

   initial begin
      // Reset state
      edges(1);
      chk("rst_l", l_signal, 3'b000);
      chk("rst_r", r_signal, 3'b000);
      chk("rst_err", {2'b00, error}, 3'b000);
      chk("rst_step", {2'b00, step}, 3'b000);
      @(negedge clock) reset_n = 1'b1;
      edges(2);

      // Left sequence over 20 cycles
      @(negedge clock) left = 1'b1;
      edges(1);  chk("left_e0", l_signal, 3'b000);
      edges(3);  chk("left_e3", l_signal, 3'b000); chk("left_e3_step", {2'b00, step}, 3'b000);
      edges(1);  chk("left_e4", l_signal, 3'b001); chk("left_e4_step", {2'b00, step}, 3'b001);
                 chk("left_e4_r", r_signal, 3'b000);
      edges(4);  chk("left_e8", l_signal, 3'b011);
      edges(4);  chk("left_e12", l_signal, 3'b111);
      edges(4);  chk("left_e16", l_signal, 3'b000);
      edges(3);
      @(negedge clock) left = 1'b0;

      // Left arriving exactly when the idle prescaler would step
      edges(4);
      @(negedge clock) left = 1'b1;
      edges(1);  chk("coinc_step", {2'b00, step}, 3'b000); chk("coinc_l", l_signal, 3'b000);
      edges(3);  chk("coinc_e3", l_signal, 3'b000);
      edges(1);  chk("coinc_e4", l_signal, 3'b001); chk("coinc_e4_step", {2'b00, step}, 3'b001);
      @(negedge clock) left = 1'b0;
      edges(2);

      // Error lockout
      @(negedge clock) begin left = 1'b1; right = 1'b1; brake = 1'b1; end
      edges(1);  chk("err_entry", {2'b00, error}, 3'b001); chk("err_l", l_signal, 3'b000);
                 chk("err_r", r_signal, 3'b000);
      edges(5);
      @(negedge clock) right = 1'b0;
      edges(6);  chk("err_hold", {2'b00, error}, 3'b001); chk("err_hold_l", l_signal, 3'b000);
      @(negedge clock) begin brake = 1'b0; left = 1'b0; end
      edges(1);  chk("err_exit", {2'b00, error}, 3'b000); chk("err_exit_l", l_signal, 3'b000);
      edges(1);

      // Hazard over left, then back to left via idle
      @(negedge clock) left = 1'b1;
      edges(3);
      @(negedge clock) hazard = 1'b1;
      edges(1);  chk("haz_h0", l_signal, 3'b000);
      edges(3);  chk("haz_h3", r_signal, 3'b000);
      edges(1);  chk("haz_h4_l", l_signal, 3'b111); chk("haz_h4_r", r_signal, 3'b111);
      edges(4);  chk("haz_h8", l_signal, 3'b000);
      edges(2);
      @(negedge clock) hazard = 1'b0;
      edges(1);  chk("haz_idle", l_signal, 3'b000);
      edges(1);  chk("haz_relef", l_signal, 3'b000);
      edges(3);  chk("haz_relef3", l_signal, 3'b000);
      edges(1);  chk("haz_relef4", l_signal, 3'b001);
      @(negedge clock) left = 1'b0;
      edges(2);

      // Right sequence with brake, then brake in idle
      @(negedge clock) begin right = 1'b1; brake = 1'b1; end
      edges(1);  chk("rb_l", l_signal, 3'b111); chk("rb_r0", r_signal, 3'b000);
      edges(4);  chk("rb_r4", r_signal, 3'b100); chk("rb_l4", l_signal, 3'b111);
      edges(4);  chk("rb_r8", r_signal, 3'b110);
      edges(4);  chk("rb_r12", r_signal, 3'b111);
      @(negedge clock) right = 1'b0;
      edges(1);  chk("brk_idle_l", l_signal, 3'b111); chk("brk_idle_r", r_signal, 3'b111);
      edges(2);
      @(negedge clock) brake = 1'b0;
      edges(1);  chk("brk_off", l_signal, 3'b000);

      // Reset mid-sequence
      @(negedge clock) left = 1'b1;
      edges(9);  chk("mid_phase2", l_signal, 3'b011);
      @(negedge clock) reset_n = 1'b0;
      edges(1);  chk("mid_rst_l", l_signal, 3'b000); chk("mid_rst_r", r_signal, 3'b000);
                 chk("mid_rst_step", {2'b00, step}, 3'b000);
      @(negedge clock) reset_n = 1'b1;
      edges(1);  chk("post_rst0", l_signal, 3'b000);
      edges(3);  chk("post_rst3", l_signal, 3'b000);
      edges(1);  chk("post_rst4", l_signal, 3'b001);
      @(negedge clock) left = 1'b0;
      edges(2);

      // Mixed directed vectors, checked by the model
      foreach (tbl[i]) begin
         @(negedge clock) begin
            left = tbl[i].l; right = tbl[i].r; hazard = tbl[i].h; brake = tbl[i].b;
         end
         repeat (tbl[i].cycles) @(negedge clock);
      end

      edges(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tail_light_ctrl.md
TAIL_LIGHT_CTRL -- requirements
Module: tail_light_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 12500000, clock cycles per sequence step (4 Hz at 50 MHz); legal range 2..2^24.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 left  input  1  left-turn switch request, level.
REQ-005 right  input  1  right-turn switch request, level.
REQ-006 hazard  input  1  hazard switch request, level.
REQ-007 brake  input  1  brake pedal, level.
REQ-008 l_signal  output  3  left lamp bank, bit0 innermost.
REQ-009 r_signal  output  3  right lamp bank, bit2 innermost.
REQ-010 error  output  1  high while in ERROR state.
REQ-011 step  output  1  one-cycle pulse marking each sequence advance (debug/bench observation).

Function
REQ-012 States IDLE, LEFT, RIGHT, HAZARD, ERROR; one transition evaluated per clock, priority top-down as listed per state.
REQ-013 IDLE: hazard->HAZARD; left&right->ERROR; left->LEFT; right->RIGHT; else stay.
REQ-014 LEFT: hazard->HAZARD; right->ERROR; !left->IDLE; else stay. RIGHT is symmetric (left->ERROR, !right->IDLE).
REQ-015 HAZARD: !hazard->IDLE; else stay; left/right ignored.
REQ-016 ERROR: hazard->HAZARD; !left&!right->IDLE; else stay (lockout holds while either switch remains on).
REQ-017 Prescaler counts 0..TICK_DIV-1, wraps to 0; step=1 exactly in the cycle count==TICK_DIV-1.
REQ-018 Prescaler and 2-bit phase counter clear to 0 on every state change, so the first step occurs TICK_DIV cycles after entry.
REQ-019 Phase advances 0->1->2->3->0 on each step in LEFT/RIGHT; in HAZARD phase bit0 toggles on each step; phase held at 0 in IDLE/ERROR.
REQ-020 LEFT pattern on l_signal by phase: 000, 001, 011, 111; RIGHT pattern on r_signal: 000, 100, 110, 111.
REQ-021 HAZARD: both banks 111 when phase bit0=1, 000 otherwise.
REQ-022 Non-sequencing bank in LEFT/RIGHT, and both banks in IDLE: 111 if brake else 000.
REQ-023 ERROR: both banks 000 regardless of brake; error=1.
REQ-024 Brake never alters a sequencing bank or HAZARD pattern.
REQ-025 Outputs registered: lamp, error and step values reflect state/phase/brake sampled at the previous edge (one-cycle latency input->output).
REQ-026 Simultaneous step and state change: state change wins; phase cleared, no advance.

Reset
REQ-027 reset_n=0 at an edge forces IDLE, prescaler=0, phase=0, l_signal=000, r_signal=000, error=0, step=0, overriding all inputs including mid-sequence.
REQ-028 First state evaluation occurs at the first edge with reset_n=1.

Structure
REQ-029 Package tail_light_pkg holds the state enumeration, the four LEFT and four RIGHT pattern constants, and the TICK_DIV default.
REQ-030 Prescaler is a separate sub-module blink_prescaler (inputs clock, reset_n, clear; output step; parameter TICK_DIV); the FSM, phase counter and output decode stay in tail_light_ctrl.

Verification (TICK_DIV=4)
REQ-031 left held 20 cycles from IDLE -> l_signal 000,001,011,111,000 changing every 4 cycles; r_signal 000; step pulses every 4th cycle.
REQ-032 left+right together, then release right only -> error=1, both banks 000 until left also released; then IDLE, error=0.
REQ-033 hazard with left on -> both banks alternate 000/111 every 4 cycles; drop hazard with left still on -> IDLE one cycle, then LEFT from phase 0.
REQ-034 right sequencing plus brake -> l_signal 111, r_signal continues 000,100,110,111; brake in IDLE -> both 111.
REQ-035 reset_n=0 during LEFT phase 2 -> next cycle l_signal=000, r_signal=000, step=0; after release, sequence restarts from 000.
REQ-036 left asserted on the cycle a step would fire -> no advance that cycle; first l_signal=001 exactly 4 cycles after LEFT entry.
